mips_multi: RTL and testbench

- Multicycle 32-bit MIPS processor core (controller FSM plus datapath) with a single unified instruction/data memory port.
- Sits under the system top, next to a word-addressed RAM.
- The RAM returns readdata combinationally from adr and writes on the rising clk edge when memwrite=1.
- Supported instructions: lw, sw, add, sub, and, or, slt, beq, addi, j.

---
 rtl/mips_multi_pkg.sv | 40 ++++
 rtl/mips_multi_ctrl.sv | 109 ++++++++++
 rtl/mips_multi.sv | 120 ++++++++++++
 tb/tb_mips_multi.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_multi_pkg.sv
// Shared constants and types for the mips_multi multicycle core:
// opcodes, funct codes, ALU operations and FSM state encodings.
package mips_multi_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU_ZERO covers unsupported funct codes, which must produce 0.
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO
    } alu_ctrl_e;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_multi_ctrl.sv
// Controller for mips_multi: decodes the current FSM state, opcode and funct
// into datapath control signals and the next FSM state.
module mips_multi_ctrl
    import mips_multi_pkg::*;
(
    input  logic [3:0]  state_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output logic        iord_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output alu_ctrl_e   alu_ctrl_o,
    output logic [1:0]  pc_src_o,
    output logic        pc_write_o,
    output logic        branch_o,
    output logic        mem_write_o,
    output logic [3:0]  state_d_o
);

    always_comb begin
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = ALU_ADD;
        pc_src_o     = 2'b00;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        mem_write_o  = 1'b0;
        state_d_o    = S_FETCH;
        case (state_i)
            S_FETCH: begin
                ir_write_o  = 1'b1;
                alu_src_b_o = 2'b01;
                pc_write_o  = 1'b1;
                state_d_o   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_LW, OP_SW: state_d_o = S_MEMADR;
                    OP_RTYPE:     state_d_o = S_EXECUTE;
                    OP_BEQ:       state_d_o = S_BRANCH;
                    OP_ADDI:      state_d_o = S_ADDIEX;
                    OP_J:         state_d_o = S_JUMP;
                    default:      state_d_o = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d_o   = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_o    = 1'b1;
                state_d_o = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_o = 1'b1;
                case (funct_i)
                    FUNCT_ADD: alu_ctrl_o = ALU_ADD;
                    FUNCT_SUB: alu_ctrl_o = ALU_SUB;
                    FUNCT_AND: alu_ctrl_o = ALU_AND;
                    FUNCT_OR:  alu_ctrl_o = ALU_OR;
                    FUNCT_SLT: alu_ctrl_o = ALU_SLT;
                    default:   alu_ctrl_o = ALU_ZERO;
                endcase
                state_d_o = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = ALU_SUB;
                pc_src_o    = 2'b01;
                branch_o    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d_o   = S_ADDIWB;
            end
            S_ADDIWB: reg_write_o = 1'b1;
            S_JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
            end
            default: state_d_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multi.sv
// Multicycle 32-bit MIPS core: architectural registers, register file, ALU
// and muxes, sequenced by mips_multi_ctrl over a single memory port.
module mips_multi
    import mips_multi_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output logic        memwrite,
    input  logic [31:0] readdata
);

    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic [3:0]  state_q, state_d;
    logic [31:0] rf_q [32];

    logic        iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic        pc_write, branch, mem_write;
    logic [1:0]  alu_src_b, pc_src;
    alu_ctrl_e   alu_ctrl;

    logic [4:0]  rs, rt, rd, rf_wa;
    logic [31:0] imm_ext, rd1, rd2, src_a, src_b, alu_result, pc_next, rf_wd;
    logic        rf_we;

    mips_multi_ctrl u_ctrl (
        .state_i      (state_q),
        .opcode_i     (ir_q[31:26]),
        .funct_i      (ir_q[5:0]),
        .iord_o       (iord),
        .ir_write_o   (ir_write),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_ctrl_o   (alu_ctrl),
        .pc_src_o     (pc_src),
        .pc_write_o   (pc_write),
        .branch_o     (branch),
        .mem_write_o  (mem_write),
        .state_d_o    (state_d)
    );

    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign imm_ext = sign_ext(ir_q[15:0]);
    assign rd1     = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rd2     = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    // Reset overrides the port immediately, whatever state the FSM was in.
    assign adr       = reset ? RESET_PC : (iord ? aluout_q : pc_q);
    assign writedata = b_q;
    assign memwrite  = mem_write & ~reset;

    always_comb begin
        src_a = alu_src_a ? a_q : pc_q;
        case (alu_src_b)
            2'b00:   src_b = b_q;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = imm_ext;
            default: src_b = {imm_ext[29:0], 2'b00};
        endcase
        case (alu_ctrl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        case (pc_src)
            2'b01:   pc_next = aluout_q;
            2'b10:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_next = alu_result;
        endcase
        pc_d     = (pc_write | (branch & (alu_result == 32'd0))) ? pc_next : pc_q;
        ir_d     = ir_write ? readdata : ir_q;
        mdr_d    = (state_q == S_MEMRD) ? readdata : mdr_q;
        a_d      = (state_q == S_DECODE) ? rd1 : a_q;
        b_d      = (state_q == S_DECODE) ? rd2 : b_q;
        aluout_d = alu_result;
        rf_wa    = reg_dst ? rd : rt;
        rf_wd    = mem_to_reg ? mdr_q : aluout_q;
        rf_we    = reg_write & ~reset & (rf_wa != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            state_q  <= S_FETCH;
            ir_q     <= 32'd0;
            mdr_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_wa] <= rf_wd;
    end

endmodule

// File: tb/tb_mips_multi.sv
// Directed bench for mips_multi: runs small hand-assembled programs from a
// behavioural word RAM and checks stores, fetch addresses and cycle timing.
module tb_mips_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr, writedata, readdata;
    logic        memwrite;

    logic [31:0] mem [64];
    logic [31:0] image [64];
    logic        load = 1'b0;
    int          cyc = 0;

    logic [31:0] adr_log [256];
    logic [31:0] st_adr [16];
    logic [31:0] st_dat [16];
    int          st_cyc [16];
    int          n_st = 0;

    int n_vec = 0;
    int n_err = 0;

    mips_multi #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    assign readdata = mem[adr[7:2]];

    always @(posedge clk) begin
        if (load) mem <= image;
        else if (memwrite) mem[adr[7:2]] <= writedata;
        cyc <= reset ? 0 : cyc + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            n_st = 0;
        end else begin
            if (cyc < 256) adr_log[cyc] = adr;
            if (memwrite && n_st < 16) begin
                st_adr[n_st] = adr;
                st_dat[n_st] = writedata;
                st_cyc[n_st] = cyc;
                n_st = n_st + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'b000010, target};
    endfunction

    task automatic clear_image();
        for (int i = 0; i < 64; i++) image[i] = 32'd0;
    endtask

    // Loads image, holds reset for two cycles, then runs ncyc cycles.
    task automatic run_prog(input string name, input int ncyc);
        load  = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check_eq({name, "_rst_adr"}, adr, 32'd0);
        check_eq({name, "_rst_memwrite"}, {31'd0, memwrite}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_a [7];

    initial begin
        // Program A: ALU path and R-type results, each stored to 84.
        clear_image();
        image[0]  = enc_i(6'b001000, 5'd0, 5'd2, 16'd5);
        image[1]  = enc_i(6'b001000, 5'd0, 5'd3, 16'd12);
        image[2]  = enc_r(5'd2, 5'd3, 5'd4, 6'b100000);
        image[3]  = enc_i(6'b101011, 5'd0, 5'd4, 16'd84);
        image[4]  = enc_r(5'd3, 5'd2, 5'd5, 6'b100010);
        image[5]  = enc_i(6'b101011, 5'd0, 5'd5, 16'd84);
        image[6]  = enc_r(5'd2, 5'd3, 5'd5, 6'b100100);
        image[7]  = enc_i(6'b101011, 5'd0, 5'd5, 16'd84);
        image[8]  = enc_r(5'd2, 5'd3, 5'd5, 6'b100101);
        image[9]  = enc_i(6'b101011, 5'd0, 5'd5, 16'd84);
        image[10] = enc_r(5'd2, 5'd3, 5'd6, 6'b101010);
        image[11] = enc_i(6'b101011, 5'd0, 5'd6, 16'd84);
        image[12] = enc_r(5'd3, 5'd2, 5'd6, 6'b101010);
        image[13] = enc_i(6'b101011, 5'd0, 5'd6, 16'd84);
        image[14] = enc_i(6'b001000, 5'd0, 5'd7, 16'hFFFF);
        image[15] = enc_i(6'b001000, 5'd0, 5'd8, 16'd1);
        image[16] = enc_r(5'd7, 5'd8, 5'd6, 6'b101010);
        image[17] = enc_i(6'b101011, 5'd0, 5'd6, 16'd84);
        image[18] = enc_j(26'd18);
        run_prog("A", 90);
        check_eq("A_fetch0_adr", adr_log[0], 32'd0);
        check_eq("A_decode0_adr", adr_log[1], 32'd4);
        check_eq("A_store_count", n_st, 32'd7);
        check_eq("A_st0_cycle", st_cyc[0], 32'd15);
        check_eq("A_st0_adr", st_adr[0], 32'd84);
        exp_a = '{32'd17, 32'd7, 32'd4, 32'd13, 32'd1, 32'd0, 32'd1};
        for (int i = 0; i < 7; i++) check_eq($sformatf("A_st%0d_dat", i), st_dat[i], exp_a[i]);
        check_eq("A_mem84", mem[21], 32'd1);

        // Program B: store, load back, store to a second address.
        clear_image();
        image[0] = enc_i(6'b001000, 5'd0, 5'd2, 16'd17);
        image[1] = enc_i(6'b101011, 5'd0, 5'd2, 16'd84);
        image[2] = enc_i(6'b100011, 5'd0, 5'd7, 16'd84);
        image[3] = enc_i(6'b101011, 5'd0, 5'd7, 16'd88);
        image[4] = enc_j(26'd4);
        run_prog("B", 30);
        check_eq("B_store_count", n_st, 32'd2);
        check_eq("B_lw_memrd_adr", adr_log[11], 32'd84);
        check_eq("B_st1_adr", st_adr[1], 32'd88);
        check_eq("B_st1_dat", st_dat[1], 32'd17);
        check_eq("B_lw_sw_cycles", st_cyc[1] - st_cyc[0], 32'd9);
        check_eq("B_mem88", mem[22], 32'd17);

        // Program C: taken/not-taken beq, j, unknown opcode, write to $0.
        clear_image();
        image[0]  = enc_i(6'b001000, 5'd0, 5'd2, 16'd5);
        image[1]  = enc_i(6'b001000, 5'd0, 5'd3, 16'd12);
        image[2]  = enc_i(6'b000100, 5'd2, 5'd2, 16'd1);
        image[3]  = enc_i(6'b101011, 5'd0, 5'd2, 16'd92);
        image[4]  = enc_i(6'b000100, 5'd2, 5'd3, 16'd1);
        image[5]  = enc_i(6'b101011, 5'd0, 5'd2, 16'd96);
        image[6]  = enc_j(26'h10);
        image[7]  = enc_i(6'b101011, 5'd0, 5'd2, 16'd100);
        image[16] = 32'hFC00_0000;
        image[17] = enc_r(5'd2, 5'd3, 5'd0, 6'b100000);
        image[18] = enc_i(6'b101011, 5'd0, 5'd0, 16'd104);
        image[19] = enc_j(26'd19);
        run_prog("C", 45);
        check_eq("C_store_count", n_st, 32'd2);
        check_eq("C_st0_adr", st_adr[0], 32'd96);
        check_eq("C_st0_dat", st_dat[0], 32'd5);
        check_eq("C_beq_cycles", st_cyc[0], 32'd17);
        check_eq("C_jump_fetch_adr", adr_log[21], 32'h40);
        check_eq("C_unknown_cycles", st_cyc[1], 32'd30);
        check_eq("C_st1_adr", st_adr[1], 32'd104);
        check_eq("C_r0_writedata", st_dat[1], 32'd0);
        check_eq("C_mem92_untouched", mem[23], 32'd0);
        check_eq("C_mem100_untouched", mem[25], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
